dac_multi: RTL
==============

DAC_MULTI -- requirements
Module: dac_multi

Interface
REQ-001 Parameter NCH, default 2, number of DAC channels (1..16).
REQ-002 Parameter DW, default 16, DAC code width in bits (8..20); frame width FW = DW+8.
REQ-003 Parameter CLK_DIV, default 4, clk_100M cycles per sclk half-period (>=1).
REQ-004 Parameter SYNC_GAP, default 4, minimum clk_100M cycles sync stays high between frames (>=1).
REQ-005 Parameter INIT_ON_RESET, default 1, when 1 all channels are pending at reset release.
REQ-006 Parameter REFRESH, default 0, when 1 the block re-sends every channel continuously, round robin.
REQ-007 clk_100M  input  1  sole clock, all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 ch_data  input  NCH*DW  packed codes, channel i at bits [i*DW +: DW].
REQ-010 ch_load  input  NCH  per-channel one-cycle update strobe.
REQ-011 sclk  output  1  DAC serial clock.
REQ-012 sdata  output  1  DAC serial data, MSB first.
REQ-013 sync  output  1  DAC frame select, active-low.
REQ-014 busy  output  1  high while the FSM is not IDLE.
REQ-015 done  output  1  one-cycle pulse when a frame completes.
REQ-016 done_ch  output  clog2(NCH) min 1  channel index of the frame flagged by done.

Function
REQ-017 ch_load[i] high copies ch_data slice i into shadow[i] and sets pending[i] on the same edge.
REQ-018 The FSM has states IDLE, LOAD, SHIFT and GAP, encoded as a package enum.
REQ-019 IDLE -> LOAD when any pending bit is set, or always when REFRESH=1.
REQ-020 Arbitration is round robin: the first pending channel at or after last_sent+1, mod NCH.
REQ-021 LOAD lasts 1 cycle: it latches frame = {4'b0011, ch[3:0], shadow[ch]}, clears pending[ch], drives sync low and sdata to frame MSB.
REQ-022 In SHIFT, sclk rises CLK_DIV cycles after sync falls and toggles every CLK_DIV cycles thereafter.
REQ-023 sdata changes only on sclk rising edges, except bit FW-1, which is presented at sync fall; the DAC samples on the falling edge.
REQ-024 sync rises CLK_DIV cycles after the FW-th sclk falling edge, so sync is low exactly (2*FW+1)*CLK_DIV cycles.
REQ-025 done pulses and done_ch is set on the cycle sync rises; the FSM then enters GAP for SYNC_GAP cycles, then returns to IDLE.
REQ-026 ch_load for the channel currently in SHIFT updates its shadow and re-sets pending; the in-flight frame is unaffected and the new value is sent later.
REQ-027 Simultaneous ch_load on several channels sets all of them pending; they are served in round-robin order, one frame each.
REQ-028 A repeated ch_load before transmission overwrites shadow, and only the latest value is sent.
REQ-029 sclk idles low, and sdata idles low outside LOAD/SHIFT.

Reset
REQ-030 While rst is high: sync=1, sclk=0, sdata=0, busy=0, done=0, done_ch=0, FSM=IDLE, shadow=0, last_sent=NCH-1.
REQ-031 Reset asserted mid-frame immediately forces sync high and sclk low (asynchronously), abandoning the frame.
REQ-032 pending is cleared by reset, then set to all ones in the first cycle after release when INIT_ON_RESET=1.

Structure
REQ-033 Package dac_multi_pkg holds the state enum, CMD_WRITE_UPDATE=4'b0011, and a function returning FW from DW.
REQ-034 One sub-module, dac_frame_shifter, owns the LOAD/SHIFT/GAP timing and serialisation; arbitration, shadows and pending stay in dac_multi.

Verification (NCH=2, DW=16, CLK_DIV=2, SYNC_GAP=4, INIT_ON_RESET=0 unless stated)
REQ-035 ch_load=2'b01 with code 0x8000 -> one frame 0x308000 MSB first, sync low 98 cycles, 24 falling sclk edges, done with done_ch=0.
REQ-036 ch_load=2'b11 with codes 0x1234/0xABCD -> frames 0x301234 then 0x31ABCD, with sync high >=4 cycles between them.
REQ-037 ch_load[0] with 0x0001 mid-SHIFT of channel 0 (sending 0x00FF) -> first frame completes with 0x00FF, second frame carries 0x0001.
REQ-038 rst asserted at sclk edge 10 -> sync=1 and sclk=0 asynchronously; with INIT_ON_RESET=1, after release frames for ch0 then ch1 are sent with data 0.
REQ-039 REFRESH=1 and no loads -> continuous alternating frames for ch0/ch1, with busy never low for more than 1 cycle.
REQ-040 Checker: sdata is stable around every sclk falling edge, and sclk stays low whenever sync is high.

Source files
------------

// File: rtl/dac_multi_pkg.sv
// Shared types and constants for the multi-channel serial DAC front end.
// Frame layout: {command nibble, channel nibble, DW-bit code}.
package dac_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_e;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

    function automatic int frame_width(input int dw);
        return dw + 8;
    endfunction

endpackage

// File: rtl/dac_frame_shifter.sv
// Serialises one DAC frame: sync low, sclk generation, MSB-first sdata, then a sync-high gap.
// Accepts start_i only in IDLE; frame length is fixed, so no backpressure beyond busy_o.
module dac_frame_shifter
    import dac_multi_pkg::*;
#(
    parameter int FW       = 24,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_GAP = 4,
    parameter int TW       = 1
) (
    input  logic          clk_100M,
    input  logic          rst,
    input  logic          start_i,
    input  logic [FW-1:0] frame_i,
    input  logic [TW-1:0] tag_i,
    output logic          sclk_o,
    output logic          sdata_o,
    output logic          sync_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [TW-1:0] done_tag_o
);

    localparam int CMAX = (CLK_DIV > SYNC_GAP) ? CLK_DIV : SYNC_GAP;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam int EW   = $clog2(2 * FW + 2);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [EW-1:0]   edge_q, edge_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [TW-1:0]   tag_q, tag_d, dtag_q, dtag_d;
    logic            sclk_q, sclk_d, sdata_q, sdata_d, sync_q, sync_d, done_q, done_d;

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            frame_q <= '0;
            tag_q   <= '0;
            dtag_q  <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            sync_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            frame_q <= frame_d;
            tag_q   <= tag_d;
            dtag_q  <= dtag_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
        end
    end

    // edge_q counts completed half-periods; even values precede a rising edge,
    // and the (2*FW+1)-th event closes the frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        frame_d = frame_q;
        tag_d   = tag_q;
        dtag_d  = dtag_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        sync_d  = sync_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdata_d = 1'b0;
                if (start_i) begin
                    state_d = ST_LOAD;
                    frame_d = frame_i;
                    tag_d   = tag_i;
                    sync_d  = 1'b0;
                    sdata_d = frame_i[FW-1];
                    cnt_d   = '0;
                    edge_d  = '0;
                end
            end
            ST_LOAD, ST_SHIFT: begin
                if (state_q == ST_LOAD) state_d = ST_SHIFT;
                if (cnt_q == CNTW'(CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    edge_d = edge_q + 1'b1;
                    if (edge_q == EW'(2 * FW)) begin
                        sync_d  = 1'b1;
                        sdata_d = 1'b0;
                        done_d  = 1'b1;
                        dtag_d  = tag_q;
                        state_d = ST_GAP;
                    end else if (!edge_q[0]) begin
                        sclk_d = 1'b1;
                        // The MSB was already presented at sync fall; hold it through the first falling edge.
                        if (edge_q != '0) begin
                            frame_d = {frame_q[FW-2:0], 1'b0};
                            sdata_d = frame_q[FW-2];
                        end
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                sdata_d = 1'b0;
                if (cnt_q == CNTW'(SYNC_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sclk_o     = sclk_q;
    assign sdata_o    = sdata_q;
    assign sync_o     = sync_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign done_tag_o = dtag_q;

endmodule

// File: rtl/dac_multi.sv
// Multi-channel DAC front end: per-channel shadow codes, pending flags and round-robin arbitration.
// One frame per pending channel; ch_load is always accepted and simply re-arms the channel.
module dac_multi
    import dac_multi_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int DW            = 16,
    parameter int CLK_DIV       = 4,
    parameter int SYNC_GAP      = 4,
    parameter int INIT_ON_RESET = 1,
    parameter int REFRESH       = 0,
    localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_load,
    output logic              sclk,
    output logic              sdata,
    output logic              sync,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     done_ch
);

    localparam int FW         = frame_width(DW);
    localparam bit REFRESH_EN = (REFRESH != 0);
    localparam bit INIT_EN    = (INIT_ON_RESET != 0);

    logic [DW-1:0]  shadow_q [NCH];
    logic [DW-1:0]  shadow_d [NCH];
    logic [NCH-1:0] pending_q, pending_d;
    logic [CW-1:0]  last_q, last_d, sel;
    logic           init_q, found, start, shifter_busy;
    logic [FW-1:0]  frame;
    int             idx;

    // Scan from the farthest candidate back to last_q+1 so the nearest pending channel wins.
    always_comb begin
        sel   = last_q;
        found = 1'b0;
        idx   = 0;
        for (int off = NCH; off >= 1; off--) begin
            idx = int'(last_q) + off;
            if (idx >= NCH) idx = idx - NCH;
            if (pending_q[CW'(idx)]) begin
                sel   = CW'(idx);
                found = 1'b1;
            end
        end
        if (REFRESH_EN) begin
            idx = int'(last_q) + 1;
            if (idx >= NCH) idx = 0;
            sel = CW'(idx);
        end
    end

    assign start = !shifter_busy && (found || REFRESH_EN);
    assign frame = {CMD_WRITE_UPDATE, 4'(sel), shadow_q[sel]};

    // A load on the same edge as the channel's launch re-arms it after the clear.
    always_comb begin
        pending_d = pending_q;
        last_d    = last_q;
        for (int i = 0; i < NCH; i++) shadow_d[i] = shadow_q[i];
        if (start) begin
            pending_d[sel] = 1'b0;
            last_d         = sel;
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_load[i]) begin
                shadow_d[i]  = ch_data[i*DW +: DW];
                pending_d[i] = 1'b1;
            end
        end
        if (init_q && INIT_EN) pending_d = '1;
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            init_q    <= 1'b1;
            pending_q <= '0;
            last_q    <= CW'(NCH - 1);
            for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
        end else begin
            init_q    <= 1'b0;
            pending_q <= pending_d;
            last_q    <= last_d;
            for (int i = 0; i < NCH; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    dac_frame_shifter #(
        .FW       (FW),
        .CLK_DIV  (CLK_DIV),
        .SYNC_GAP (SYNC_GAP),
        .TW       (CW)
    ) u_shifter (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .start_i    (start),
        .frame_i    (frame),
        .tag_i      (sel),
        .sclk_o     (sclk),
        .sdata_o    (sdata),
        .sync_o     (sync),
        .busy_o     (shifter_busy),
        .done_o     (done),
        .done_tag_o (done_ch)
    );

    assign busy = shifter_busy;

endmodule
